// File: rtl/fmul_issue_ctrl.sv
// fmul_issue_ctrl: issue/collect wrapper around a fixed-latency FMUL32.
// Requests are buffered in an input FIFO and issued one per cycle into the
// non-stallable multiplier. Each request's tag travels in a shadow valid/tag pipe.
// Results land in an output FIFO. A credit check (out_cnt + inflight_cnt) keeps
// that FIFO from overflowing.
// Optional feature: define FMUL_ISSUE_STATS_EN to build the issue and
// invalid-result counters. Otherwise stat_* are tied to zero.
module fmul_issue_ctrl #(
    parameter int DATA_W        = 32,
    parameter int OPERATION_NUM = 4,
    parameter int TAG_W         = 4,
    parameter int IN_DEPTH      = 4,
    parameter int OUT_DEPTH     = 4,
    parameter int PIPE_LAT      = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [DATA_W-1:0]                req_op1,
    input  logic [DATA_W-1:0]                req_op2,
    input  logic [$clog2(OPERATION_NUM)-1:0] req_opc,
    input  logic [1:0]                       req_rmode,
    input  logic [TAG_W-1:0]                 req_tag,
    output logic [DATA_W-1:0]                fmul_op1,
    output logic [DATA_W-1:0]                fmul_op2,
    output logic [$clog2(OPERATION_NUM)-1:0] fmul_opc,
    output logic [1:0]                       fmul_rmode,
    input  logic [31:0]                      fmul_result,
    input  logic                             fmul_val,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [31:0]                      rsp_result,
    output logic                             rsp_val,
    output logic [TAG_W-1:0]                 rsp_tag,
    output logic                             busy,
    output logic [31:0]                      stat_issued,
    output logic [31:0]                      stat_invalid
);

    localparam int OPC_W  = $clog2(OPERATION_NUM);
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int IN_CW  = IN_AW + 1;
    localparam int CNT_W  = OUT_AW + 1;
    localparam int REQ_W  = 2 * DATA_W + OPC_W + 2 + TAG_W;
    localparam int RSP_W  = 32 + 1 + TAG_W;

    // ---------------- input FIFO ----------------
    logic [REQ_W-1:0]  r_in_mem [IN_DEPTH];
    logic [IN_AW-1:0]  r_in_wptr;
    logic [IN_AW-1:0]  r_in_rptr;
    logic [IN_CW-1:0]  r_in_cnt;
    logic              r_alive;

    logic              w_in_full;
    logic              w_in_empty;
    logic              w_push;
    logic              w_issue;
    logic              w_credit_ok;
    logic [CNT_W:0]    w_credit_sum;
    logic [DATA_W-1:0] w_h_op1;
    logic [DATA_W-1:0] w_h_op2;
    logic [OPC_W-1:0]  w_h_opc;
    logic [1:0]        w_h_rmode;
    logic [TAG_W-1:0]  w_h_tag;

    // ---------------- in-flight pipe / output FIFO ----------------
    logic [PIPE_LAT-1:0] r_pipe_v;
    logic [TAG_W-1:0]    r_pipe_tag [PIPE_LAT];
    logic [CNT_W-1:0]    r_infl_cnt;
    logic [RSP_W-1:0]    r_out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0]   r_out_wptr;
    logic [OUT_AW-1:0]   r_out_rptr;
    logic [CNT_W-1:0]    r_out_cnt;

    logic                w_cap;
    logic                w_pop;
    logic                w_out_empty;
    logic [31:0]         w_o_result;
    logic                w_o_val;
    logic [TAG_W-1:0]    w_o_tag;

    assign w_in_full  = (r_in_cnt == IN_CW'(IN_DEPTH));
    assign w_in_empty = (r_in_cnt == '0);
    // r_alive holds req_ready low through reset and for the first cycle after release.
    assign req_ready  = r_alive & ~w_in_full;
    assign w_push     = req_valid & req_ready;

    assign {w_h_op1, w_h_op2, w_h_opc, w_h_rmode, w_h_tag} = r_in_mem[r_in_rptr];

    // Registered counts only: a response popped this cycle frees credit next cycle.
    assign w_credit_sum = {1'b0, r_out_cnt} + {1'b0, r_infl_cnt};
    assign w_credit_ok  = (w_credit_sum < (CNT_W + 1)'(OUT_DEPTH));
    assign w_issue      = ~w_in_empty & w_credit_ok;

    // Input FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive   <= 1'b0;
            r_in_wptr <= '0;
            r_in_rptr <= '0;
            r_in_cnt  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_alive <= 1'b1;
            if (w_push)  r_in_wptr <= r_in_wptr + 1'b1;
            if (w_issue) r_in_rptr <= r_in_rptr + 1'b1;
            r_in_cnt <= r_in_cnt + IN_CW'(w_push) - IN_CW'(w_issue);
        end
    end

    // Input FIFO storage.
    // NOTE: storage arrays are not reset; the counters alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_in_mem[r_in_wptr] <= {req_op1, req_op2, req_opc, req_rmode, req_tag};
    end

    // Drive FMUL32 from the FIFO head only in an issue cycle; zeros otherwise.
    always_comb begin
        // NOTE: defaults are assigned first so no path through the block infers a latch.
        fmul_op1   = '0;
        fmul_op2   = '0;
        fmul_opc   = '0;
        fmul_rmode = '0;
        if (w_issue) begin
            fmul_op1   = w_h_op1;
            fmul_op2   = w_h_op2;
            fmul_opc   = w_h_opc;
            fmul_rmode = w_h_rmode;
        end
    end

    // Valid bits of the shadow pipe and the in-flight counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_v   <= '0;
            r_infl_cnt <= '0;
        end else begin
            r_pipe_v[0] <= w_issue;
            for (int i = 1; i < PIPE_LAT; i++) r_pipe_v[i] <= r_pipe_v[i-1];
            r_infl_cnt <= r_infl_cnt + CNT_W'(w_issue) - CNT_W'(w_cap);
        end
    end

    // Tag shadow pipe. Its contents only matter where the matching valid bit is set.
    always_ff @(posedge clk) begin
        r_pipe_tag[0] <= w_h_tag;
        for (int i = 1; i < PIPE_LAT; i++) r_pipe_tag[i] <= r_pipe_tag[i-1];
    end

    // A result is captured only in the cycle its issue slot leaves the pipe.
    // FMUL32 output at any other time, including stale post-reset data, is ignored.
    assign w_cap       = r_pipe_v[PIPE_LAT-1];
    assign w_out_empty = (r_out_cnt == '0);
    assign rsp_valid   = ~w_out_empty;
    assign w_pop       = rsp_valid & rsp_ready;

    assign {w_o_result, w_o_val, w_o_tag} = r_out_mem[r_out_rptr];
    assign rsp_result = rsp_valid ? w_o_result : '0;
    assign rsp_val    = rsp_valid ? w_o_val    : 1'b0;
    assign rsp_tag    = rsp_valid ? w_o_tag    : '0;

    assign busy = ~w_in_empty | (r_infl_cnt != '0) | ~w_out_empty;

    // Output FIFO pointers and occupancy. Capture and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_wptr <= '0;
            r_out_rptr <= '0;
            r_out_cnt  <= '0;
        end else begin
            if (w_cap) r_out_wptr <= r_out_wptr + 1'b1;
            if (w_pop) r_out_rptr <= r_out_rptr + 1'b1;
            r_out_cnt <= r_out_cnt + CNT_W'(w_cap) - CNT_W'(w_pop);
        end
    end

    // Output FIFO storage.
    always_ff @(posedge clk) begin
        if (w_cap) r_out_mem[r_out_wptr] <= {fmul_result, fmul_val, r_pipe_tag[PIPE_LAT-1]};
    end

`ifdef FMUL_ISSUE_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_invalid;

    // Free-running statistics; both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_issued  <= '0;
            r_stat_invalid <= '0;
        end else begin
            if (w_issue)             r_stat_issued  <= r_stat_issued + 32'd1;
            if (w_cap && !fmul_val)  r_stat_invalid <= r_stat_invalid + 32'd1;
        end
    end

    assign stat_issued  = r_stat_issued;
    assign stat_invalid = r_stat_invalid;
`else
    assign stat_issued  = '0;
    assign stat_invalid = '0;
`endif

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Self-checking bench for fmul_issue_ctrl. A stand-in FMUL32 with a two-cycle
// latency surrounds the DUT. A queue scoreboard predicts every response from
// the accepted requests.
module tb_fmul_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready;
    logic [31:0] req_op1, req_op2;
    logic [1:0]  req_opc, req_rmode;
    logic [3:0]  req_tag;
    logic [31:0] fmul_op1, fmul_op2;
    logic [1:0]  fmul_opc, fmul_rmode;
    logic [31:0] fmul_result;
    logic        fmul_val;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_val;
    logic [3:0]  rsp_tag;
    logic        busy;
    logic [31:0] stat_issued, stat_invalid;

    always #5 clk = ~clk;

    fmul_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_opc(req_opc),
        .req_rmode(req_rmode), .req_tag(req_tag),
        .fmul_op1(fmul_op1), .fmul_op2(fmul_op2), .fmul_opc(fmul_opc),
        .fmul_rmode(fmul_rmode), .fmul_result(fmul_result), .fmul_val(fmul_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_val(rsp_val), .rsp_tag(rsp_tag), .busy(busy),
        .stat_issued(stat_issued), .stat_invalid(stat_invalid)
    );

    // Truncating single-precision multiply: NaN/Inf inputs give val=0.
    // opc/rmode are XORed into the low bits so that their routing can be observed.
    function automatic logic [32:0] ref_fmul(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] o, input logic [1:0] rm);
        logic        s;
        logic        v;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        logic [31:0] r;
        s = a[31] ^ b[31];
        v = 1'b1;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            r = 32'h7FC00000;
            v = 1'b0;
        end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
            r = {s, 31'b0};
        end else begin
            p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
            e = int'(a[30:23]) + int'(b[30:23]) - 127;
            if (p[47]) begin m = p[46:24]; e = e + 1; end
            else       m = p[45:23];
            if (e >= 255)    r = {s, 8'hFF, 23'b0};
            else if (e <= 0) r = {s, 31'b0};
            else             r = {s, e[7:0], m};
        end
        r[3:0] = r[3:0] ^ {o, rm};
        return {v, r};
    endfunction

    // Stand-in FMUL32: a two-stage pipeline with no reset.
    logic [32:0] fm_s1, fm_s2;
    always @(posedge clk) begin
        fm_s1 <= ref_fmul(fmul_op1, fmul_op2, fmul_opc, fmul_rmode);
        fm_s2 <= fm_s1;
    end
    assign fmul_result = fm_s2[31:0];
    assign fmul_val    = fm_s2[32];

    typedef struct packed {
        logic [31:0] res;
        logic        val;
        logic [3:0]  tag;
    } rsp_t;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  opc;
        logic [1:0]  rm;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        val;
    } vec_t;

    rsp_t exp_q[$];
    rsp_t last_got, prev_rsp;
    logic prev_hold;
    logic s_acc;
    int   n_vec, n_err;
    int   cyc, acc_cnt, pop_cnt;
    int   last_acc_cyc, first_pop_cyc, last_pop_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name, input int waited);
        n_vec++;
        n_err++;
        $display("FAIL %s: no progress after %0d cycles, expected completion", name, waited);
    endtask

    // One clock cycle. Sample handshakes mid-cycle, update the scoreboard,
    // then advance to the next falling edge.
    task automatic step();
        logic [32:0] f;
        rsp_t        got;
        rsp_t        exp;
        #1;
        if (prev_hold)
            check("hold_stable", 64'({rsp_valid, rsp_result, rsp_val, rsp_tag}), 64'({1'b1, prev_rsp}));
        prev_hold = rsp_valid & ~rsp_ready;
        prev_rsp  = {rsp_result, rsp_val, rsp_tag};
        s_acc = req_valid & req_ready;
        if (s_acc) begin
            f = ref_fmul(req_op1, req_op2, req_opc, req_rmode);
            exp_q.push_back({f[31:0], f[32], req_tag});
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        if (rsp_valid && rsp_ready) begin
            got = {rsp_result, rsp_val, rsp_tag};
            last_got = got;
            if (exp_q.size() == 0) begin
                bound_fail("spurious_rsp", 0);
            end else begin
                exp = exp_q.pop_front();
                check("rsp_in_order", 64'(got), 64'(exp));
            end
            pop_cnt++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] o, input logic [1:0] rm, input logic [3:0] t);
        req_op1 = a; req_op2 = b; req_opc = o; req_rmode = rm; req_tag = t;
        req_valid = 1'b1;
    endtask

    task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] o, input logic [1:0] rm, input logic [3:0] t);
        int acc0;
        acc0 = acc_cnt;
        drive_req(a, b, o, rm, t);
        for (int i = 0; i < 50 && acc_cnt == acc0; i++) step();
        req_valid = 1'b0;
        if (acc_cnt == acc0) bound_fail("send_accept", 50);
    endtask

    // A single request with rsp_ready held high: check its latency and its fields.
    task automatic run_vec(input vec_t v);
        int pop0;
        rsp_ready     = 1'b1;
        pop0          = pop_cnt;
        first_pop_cyc = -1;
        send_one(v.op1, v.op2, v.opc, v.rm, v.tag);
        for (int i = 0; i < 20 && pop_cnt == pop0; i++) step();
        if (pop_cnt == pop0) begin
            bound_fail("vec_response", 20);
        end else begin
            check("vec_latency", 64'(first_pop_cyc - last_acc_cyc), 64'd4);
            check("vec_result",  64'(last_got.res), 64'(v.res));
            check("vec_val",     64'(last_got.val), 64'(v.val));
            check("vec_tag",     64'(last_got.tag), 64'(v.tag));
        end
    endtask

    task automatic drain(input int limit);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < limit && (exp_q.size() != 0 || busy); i++) step();
        check("drained_queue", 64'(exp_q.size()), 64'd0);
    endtask

    // Assert reset mid-cycle and release it on a falling edge.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        prev_hold = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cyc   += 2;
        rst_n = 1'b1;
    endtask

    vec_t        tbl[6];
    vec_t        v_new;
    logic [31:0] bp_a[10];
    logic [31:0] bp_b[10];
    int          acc0, pop0, first_acc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h40400000, 32'h40000000, 2'd0, 2'd0, 4'd5,  32'h40C00000, 1'b1};
        tbl[1] = '{32'h3F800000, 32'h3F800000, 2'd0, 2'd0, 4'd10, 32'h3F800000, 1'b1};
        tbl[2] = '{32'hC0000000, 32'h40400000, 2'd0, 2'd0, 4'd3,  32'hC0C00000, 1'b1};
        tbl[3] = '{32'h40800000, 32'h3F000000, 2'd1, 2'd2, 4'd12, 32'h40000006, 1'b1};
        tbl[4] = '{32'h7FC00000, 32'h3F800000, 2'd0, 2'd0, 4'd15, 32'h7FC00000, 1'b0};
        tbl[5] = '{32'h00000000, 32'h40400000, 2'd3, 2'd1, 4'd0,  32'h0000000D, 1'b1};

        n_vec = 0; n_err = 0; cyc = 0; acc_cnt = 0; pop_cnt = 0;
        last_acc_cyc = 0; first_pop_cyc = -1; last_pop_cyc = 0;
        prev_hold = 1'b0; s_acc = 1'b0;
        rsp_ready = 1'b1;
        drive_req(32'h40400000, 32'h40000000, 2'd1, 2'd1, 4'd7);

        // Reset state, with a request offered so that nothing leaks through.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp",       64'({rsp_valid, rsp_result, rsp_val, rsp_tag}), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_fmul",      64'({fmul_op1, fmul_op2, fmul_opc, fmul_rmode}), 64'd0);
        check("rst_stats",     64'({stat_issued, stat_invalid}), 64'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("ready_after_rst", 64'(req_ready), 64'd1);

        // Directed vectors, one at a time.
        foreach (tbl[i]) run_vec(tbl[i]);

        // Back-to-back stream of 16 requests.
        rsp_ready     = 1'b1;
        pop0          = pop_cnt;
        first_pop_cyc = -1;
        first_acc     = cyc;
        for (int t = 0; t < 16; t++) begin
            drive_req($urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'(t));
            step();
            check("stream_ready", 64'(s_acc), 64'd1);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 40 && pop_cnt - pop0 < 16; i++) step();
        check("stream_count",   64'(pop_cnt - pop0), 64'd16);
        check("stream_first",   64'(first_pop_cyc - first_acc), 64'd4);
        check("stream_spacing", 64'(last_pop_cyc - first_pop_cyc), 64'd15);

        // Backpressure: 10 requests offered while the consumer stalls.
        drain(20);
        foreach (bp_a[i]) begin bp_a[i] = $urandom; bp_b[i] = $urandom; end
        rsp_ready = 1'b0;
        acc0 = acc_cnt;
        pop0 = pop_cnt;
        for (int c = 0; c < 30; c++) begin
            if (acc_cnt - acc0 < 10)
                drive_req(bp_a[acc_cnt - acc0], bp_b[acc_cnt - acc0], 2'd2, 2'd1, 4'(acc_cnt - acc0));
            else
                req_valid = 1'b0;
            step();
        end
        check("bp_accepted",  64'(acc_cnt - acc0), 64'd8);
        check("bp_ready_low", 64'(req_ready), 64'd0);
        check("bp_busy",      64'({busy, rsp_valid}), 64'd3);
        check("bp_no_pops",   64'(pop_cnt - pop0), 64'd0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && pop_cnt - pop0 < 10; c++) begin
            if (acc_cnt - acc0 < 10)
                drive_req(bp_a[acc_cnt - acc0], bp_b[acc_cnt - acc0], 2'd2, 2'd1, 4'(acc_cnt - acc0));
            else
                req_valid = 1'b0;
            step();
        end
        req_valid = 1'b0;
        check("bp_returned", 64'(pop_cnt - pop0), 64'd10);

        // Capture and pop in the same cycle with the output FIFO one short of full.
        drain(20);
        rsp_ready = 1'b0;
        for (int t = 0; t < 3; t++) send_one($urandom, $urandom, 2'd0, 2'd3, 4'(t + 1));
        repeat (8) step();
        pop0 = pop_cnt;
        send_one(32'h40800000, 32'h40400000, 2'd0, 2'd0, 4'd4);
        step();
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("sim_one_pop", 64'(pop_cnt - pop0), 64'd1);
        repeat (4) step();
        pop0 = pop_cnt;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10 && busy; i++) step();
        check("sim_remaining", 64'(pop_cnt - pop0), 64'd3);
        check("sim_last_res",  64'(last_got.res), 64'h41400000);

        // Reset with two in flight, three queued and two results buffered.
        drain(20);
        rsp_ready = 1'b0;
        acc0 = acc_cnt;
        for (int c = 0; c < 40 && acc_cnt - acc0 < 8; c++) begin
            drive_req($urandom, $urandom, 2'd1, 2'd0, 4'(acc_cnt - acc0));
            step();
        end
        req_valid = 1'b0;
        check("rst_setup_fill", 64'(acc_cnt - acc0), 64'd8);
        repeat (6) step();
        rsp_ready = 1'b1;
        step();
        step();
        rsp_ready = 1'b0;
        drive_req(32'h3F800000, 32'h40000000, 2'd0, 2'd0, 4'd8);
        step();
        check("rst_setup_acc", 64'(s_acc), 64'd1);
        req_valid = 1'b0;
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_flags", 64'({req_ready, rsp_valid, busy, rsp_val, rsp_tag}), 64'd0);
        check("midrst_rsp",   64'(rsp_result), 64'd0);
        check("midrst_fmul",  64'({fmul_op1, fmul_op2, fmul_opc, fmul_rmode}), 64'd0);
        exp_q.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        pop0 = pop_cnt;
        repeat (10) step();
        check("no_stale_rsp", 64'(pop_cnt - pop0), 64'd0);
        check("idle_after_rst", 64'(busy), 64'd0);
        v_new = '{32'h40400000, 32'h40000000, 2'd0, 2'd0, 4'd9, 32'h40C00000, 1'b1};
        run_vec(v_new);

        // Randomized traffic against the scoreboard.
        s_acc = 1'b0;
        req_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!req_valid || s_acc) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_op1   = $urandom;
                req_op2   = $urandom;
                req_opc   = 2'($urandom_range(0, 3));
                req_rmode = 2'($urandom_range(0, 3));
                req_tag   = 4'($urandom_range(0, 15));
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain(60);
        check("rand_idle", 64'(busy), 64'd0);

        // Statistics counters from a clean reset.
        apply_reset();
        step();
        for (int t = 0; t < 6; t++)
            send_one((t == 1 || t == 4) ? 32'h7FC00000 : 32'h40000000, 32'h3F800000, 2'd0, 2'd0, 4'(t));
        drain(30);
`ifdef FMUL_ISSUE_STATS_EN
        check("stat_issued",  64'(stat_issued),  64'd6);
        check("stat_invalid", 64'(stat_invalid), 64'd2);
`else
        check("stat_issued",  64'(stat_issued),  64'd0);
        check("stat_invalid", 64'(stat_invalid), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fmul_issue_ctrl.md
Name: fmul_issue_ctrl

Overview:
Issue/collect wrapper placed directly around an FMUL32 instance. It accepts multiply requests on a valid/ready port and buffers them in an input FIFO. It issues at most one request per cycle into FMUL32's fixed-latency, non-stallable pipeline and carries each request's tag alongside it. Results are captured into an output FIFO with a valid/ready port; a credit check guarantees the output FIFO can never overflow.

Parameters:
DATA_W, 32, operand/result width (matches FMUL32)
OPERATION_NUM, 4, opcode count; opc width = $clog2(OPERATION_NUM)
TAG_W, 4, request tag width
IN_DEPTH, 4, input FIFO entries (power of 2, >=2)
OUT_DEPTH, 4, output FIFO entries (power of 2, >= PIPE_LAT+1)
PIPE_LAT, 2, FMUL32 latency in cycles, from inputs driven to result valid

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  input FIFO not full
req_op1  in  DATA_W  operand A
req_op2  in  DATA_W  operand B
req_opc  in  $clog2(OPERATION_NUM)  opcode
req_rmode  in  2  rounding mode
req_tag  in  TAG_W  request tag
fmul_op1  out  DATA_W  to FMUL32 op1
fmul_op2  out  DATA_W  to FMUL32 op2
fmul_opc  out  $clog2(OPERATION_NUM)  to FMUL32 opc
fmul_rmode  out  2  to FMUL32 r_mode
fmul_result  in  32  from FMUL32 result
fmul_val  in  1  from FMUL32 val
rsp_valid  out  1  output FIFO not empty
rsp_ready  in  1  consumer accepts
rsp_result  out  32  result at output FIFO head
rsp_val  out  1  FMUL32 val flag at output FIFO head
rsp_tag  out  TAG_W  tag at output FIFO head
busy  out  1  any FIFO entry or in-flight op present
stat_issued  out  32  issue counter (optional feature)
stat_invalid  out  32  invalid-result counter (optional feature)

Behaviour:
- Reset (async assert, sync release): both FIFOs empty; in-flight pipe cleared; counters 0. During reset: req_ready=0, rsp_valid=0, busy=0, rsp_* =0, fmul_* =0.
- Input FIFO: push on req_valid&req_ready. req_ready = !in_full, registered count. Push into a full FIFO is impossible by construction. Simultaneous push and pop when full is not allowed, because req_ready is already 0.
- issue = !in_empty && (out_cnt + inflight_cnt < OUT_DEPTH). Counts are the registered values. A same-cycle rsp pop gives no credit that cycle.
- On issue: fmul_* is driven combinationally from the input FIFO head and the head is popped. When not issuing, fmul_* is driven to 0.
- In-flight pipe: PIPE_LAT-deep shift register of {v, tag}. Stage0 captures {issue, head tag}. inflight_cnt = popcount of v bits, maintained as a counter.
- Capture: when the last pipe stage has v=1, {fmul_result, fmul_val, tag} is pushed into the output FIFO in the same cycle FMUL32's result is valid. That is the cycle PIPE_LAT after issue, with PIPE_LAT=2.
- FMUL32 output in cycles with no valid pipe entry is ignored. This includes stale data after reset: FMUL32 has no reset.
- Timing: request accepted at edge E0 → issued in cycle C1 → result captured at edge E3 → rsp_valid in C4. Sustained throughput is 1/cycle when rsp_ready is held 1.
- Output FIFO: pop on rsp_valid&rsp_ready. rsp_* shows the head and is stable while rsp_valid&!rsp_ready. Credit makes overflow impossible. If capture and pop occur in the same cycle, both happen and out_cnt is unchanged.
- Ordering: strictly in-order; tags are returned unmodified.
- busy = !in_empty | (inflight_cnt!=0) | !out_empty.
- Reset mid-operation: all queued and in-flight requests are dropped; no response is ever produced for them.

Optional Feature:
FMUL_ISSUE_STATS_EN:
- Defined: stat_issued increments on each issue. stat_invalid increments on each capture with fmul_val=0. Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- Undefined: no counter logic is built; both ports are tied to 0.

Test Plan:
- Single op: op1=0x40400000, op2=0x40000000, MUL opcode, tag=5 → rsp_valid rises exactly 4 cycles after accept, rsp_result=0x40C00000, rsp_val=1, rsp_tag=5.
- Back-to-back stream: 16 requests, tags 0..15, rsp_ready=1 → responses in order, one per cycle, first at accept+4; req_ready stays 1 throughout.
- Backpressure: rsp_ready=0, issue 10 requests → exactly OUT_DEPTH=4 responses buffered; inflight_cnt+out_cnt never exceeds 4; req_ready falls after IN_DEPTH more are queued; releasing rsp_ready returns all 10 in order with no loss.
- Simultaneous pop and capture at out_cnt=OUT_DEPTH-1 → count unchanged, no overflow, no data corruption.
- Reset asserted with 2 ops in flight and 3 queued → all outputs 0 immediately; after release, no stale response appears; a new request returns correctly at accept+4.
- Stats (macro defined): send 6 requests, 2 with an op1 NaN operand giving val=0 → stat_issued=6, stat_invalid=2. With the macro undefined, both read 0.
